// File: rtl/fpu_operand_unpack_if.sv
// Bus bundle for the FPU operand-unpack stage: upstream operand handshake,
// downstream result handshake and a state debug tap.
interface fpu_operand_unpack_if;
  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high. Once valid_o rises, valid_o and all result fields are held
  // until that transfer happens. ready_o is high only while the stage is idle.
  logic        valid_i;
  logic        ready_o;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [2:0]  rm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rs1_o;
  logic [31:0] rs2_o;
  logic [9:0]  rs1Exp_o;
  logic [9:0]  rs2Exp_o;
  logic [23:0] rs1Sig_o;
  logic [23:0] rs2Sig_o;
  logic [5:0]  rs1Class_o;
  logic [5:0]  rs2Class_o;
  logic [2:0]  rm_o;
  logic [1:0]  state_o;

  modport master (
    output valid_i, rs1_i, rs2_i, rm_i, ready_i,
    input  ready_o, valid_o, rs1_o, rs2_o, rs1Exp_o, rs2Exp_o,
           rs1Sig_o, rs2Sig_o, rs1Class_o, rs2Class_o, rm_o, state_o
  );

  modport slave (
    input  valid_i, rs1_i, rs2_i, rm_i, ready_i,
    output ready_o, valid_o, rs1_o, rs2_o, rs1Exp_o, rs2Exp_o,
           rs1Sig_o, rs2Sig_o, rs1Class_o, rs2Class_o, rm_o, state_o
  );
endinterface

// File: rtl/fpu_operand_unpack.sv
// Classifies two single-precision operands and normalizes subnormal
// significands one bit per cycle before handing them to the multiplier.
module fpu_operand_unpack (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  fpu_operand_unpack_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] CLS_ZERO = 6'b000001;
  localparam logic [5:0] CLS_SUB  = 6'b000010;
  localparam logic [5:0] CLS_NORM = 6'b000100;
  localparam logic [5:0] CLS_INF  = 6'b001000;
  localparam logic [5:0] CLS_SNAN = 6'b010000;
  localparam logic [5:0] CLS_QNAN = 6'b100000;

  localparam logic [9:0] EXP_MIN  = 10'h382;  // -126
  localparam logic [9:0] EXP_SPEC = 10'h080;  // +128
  localparam logic [9:0] EXP_BIAS = 10'd127;

  typedef struct packed {
    logic [5:0]  cls;
    logic [9:0]  exp;
    logic [23:0] sig;
  } unpack_t;

  function automatic unpack_t classify(input logic [31:0] x);
    unpack_t r;
    r.sig = {1'b0, x[22:0]};
    r.exp = EXP_SPEC;
    r.cls = CLS_NORM;
    if (x[30:23] == 8'h00) begin
      r.exp = EXP_MIN;
      r.cls = (x[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    end else if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0)  r.cls = CLS_INF;
      else if (x[22])        r.cls = CLS_QNAN;
      else                   r.cls = CLS_SNAN;
    end else begin
      r.exp = {2'b00, x[30:23]} - EXP_BIAS;
      r.sig = {1'b1, x[22:0]};
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]  rm_q, rm_d;
  logic [9:0]  exp1_q, exp1_d, exp2_q, exp2_d;
  logic [23:0] sig1_q, sig1_d, sig2_q, sig2_d;
  logic [5:0]  cls1_q, cls1_d, cls2_q, cls2_d;
  unpack_t     u1, u2;
  logic        shift1, shift2;

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rm_d    = rm_q;
    exp1_d  = exp1_q;
    exp2_d  = exp2_q;
    sig1_d  = sig1_q;
    sig2_d  = sig2_q;
    cls1_d  = cls1_q;
    cls2_d  = cls2_q;
    u1      = classify(bus.rs1_i);
    u2      = classify(bus.rs2_i);
    shift1  = (cls1_q == CLS_SUB) && !sig1_q[23];
    shift2  = (cls2_q == CLS_SUB) && !sig2_q[23];

    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          rs1_d   = bus.rs1_i;
          rs2_d   = bus.rs2_i;
          rm_d    = bus.rm_i;
          cls1_d  = u1.cls;
          exp1_d  = u1.exp;
          sig1_d  = u1.sig;
          cls2_d  = u2.cls;
          exp2_d  = u2.exp;
          sig2_d  = u2.sig;
          state_d = ((u1.cls == CLS_SUB) || (u2.cls == CLS_SUB)) ? S_NORM : S_DONE;
        end
      end
      S_NORM: begin
        if (shift1) begin
          sig1_d = sig1_q << 1;
          exp1_d = exp1_q - 10'd1;
        end
        if (shift2) begin
          sig2_d = sig2_q << 1;
          exp2_d = exp2_q - 10'd1;
        end
        // Leave as soon as the shifted values have their integer bit set, so
        // the time spent here equals the larger leading-zero count.
        if (!((cls1_q == CLS_SUB) && !sig1_d[23]) &&
            !((cls2_q == CLS_SUB) && !sig2_d[23]))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rm_q    <= '0;
      exp1_q  <= '0;
      exp2_q  <= '0;
      sig1_q  <= '0;
      sig2_q  <= '0;
      cls1_q  <= '0;
      cls2_q  <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rm_q    <= rm_d;
      exp1_q  <= exp1_d;
      exp2_q  <= exp2_d;
      sig1_q  <= sig1_d;
      sig2_q  <= sig2_d;
      cls1_q  <= cls1_d;
      cls2_q  <= cls2_d;
    end
  end

  assign bus.ready_o    = (state_q == S_IDLE);
  assign bus.valid_o    = (state_q == S_DONE);
  assign bus.rs1_o      = rs1_q;
  assign bus.rs2_o      = rs2_q;
  assign bus.rm_o       = rm_q;
  assign bus.rs1Exp_o   = exp1_q;
  assign bus.rs2Exp_o   = exp2_q;
  assign bus.rs1Sig_o   = sig1_q;
  assign bus.rs2Sig_o   = sig2_q;
  assign bus.rs1Class_o = cls1_q;
  assign bus.rs2Class_o = cls2_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Directed bench for fpu_operand_unpack: hand-computed vectors covering
// normals, extreme subnormals, specials, backpressure and mid-flight reset.
module tb_fpu_operand_unpack;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fpu_operand_unpack_if bus ();

  fpu_operand_unpack dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    int cyc;
    cyc = 0;
    while (!bus.ready_o && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("accept_ready", 64'(bus.ready_o), 64'd1);
    bus.valid_i = 1'b1;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rm_i    = rm;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.rs1_i   = 32'h1234_5678;
    bus.rs2_i   = 32'h0000_0007;
    bus.rm_i    = 3'b111;
  endtask

  task automatic expect_result(
    input int lat,
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
    input logic [9:0] e1, input logic [23:0] s1, input logic [5:0] c1,
    input logic [9:0] e2, input logic [23:0] s2, input logic [5:0] c2,
    input int hold);
    int cyc;
    cyc = 0;
    while (!bus.valid_o && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(lat));
    check("rs1_o", 64'(bus.rs1_o), 64'(a));
    check("rs2_o", 64'(bus.rs2_o), 64'(b));
    check("rm_o", 64'(bus.rm_o), 64'(rm));
    check("exp1", 64'(bus.rs1Exp_o), 64'(e1));
    check("sig1", 64'(bus.rs1Sig_o), 64'(s1));
    check("cls1", 64'(bus.rs1Class_o), 64'(c1));
    check("exp2", 64'(bus.rs2Exp_o), 64'(e2));
    check("sig2", 64'(bus.rs2Sig_o), 64'(s2));
    check("cls2", 64'(bus.rs2Class_o), 64'(c2));
    check("ready_in_done", 64'(bus.ready_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.valid_i = 1'b1;
      bus.rs1_i   = $urandom;
      bus.rs2_i   = $urandom_range(1, 32'h007F_FFFF);
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.valid_o), 64'd1);
      check("bp_ready", 64'(bus.ready_o), 64'd0);
      check("bp_hold", {bus.rs1Exp_o, bus.rs1Sig_o, bus.rs2Sig_o, bus.rs1Class_o},
            {e1, s1, s2, c1});
      check("bp_raw", 64'(bus.rs1_o), 64'(a));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    check("post_hs_valid", 64'(bus.valid_o), 64'd0);
    check("post_hs_ready", 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.rm_i    = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_cls", {bus.rs1Class_o, bus.rs2Class_o}, 64'd0);
    check("rst_data", {bus.rs1Sig_o, bus.rs1Exp_o, bus.rm_o}, 64'd0);
    check("rst_raw", {bus.rs1_o, bus.rs2_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal x normal: 1.5 and 2.0
    send(32'h3FC0_0000, 32'h4000_0000, 3'b001);
    expect_result(0, 32'h3FC0_0000, 32'h4000_0000, 3'b001,
                  10'h000, 24'hC00000, 6'b000100, 10'h001, 24'h800000, 6'b000100, 0);

    // Extreme subnormals: lz=23 (-149) and lz=1 (-127)
    send(32'h0000_0001, 32'h0040_0000, 3'b010);
    expect_result(23, 32'h0000_0001, 32'h0040_0000, 3'b010,
                  10'h36B, 24'h800000, 6'b000010, 10'h381, 24'h800000, 6'b000010, 0);

    // Specials: INF + SNAN, then QNAN + negative zero
    send(32'h7F80_0000, 32'h7FA0_0000, 3'b000);
    expect_result(0, 32'h7F80_0000, 32'h7FA0_0000, 3'b000,
                  10'h080, 24'h000000, 6'b001000, 10'h080, 24'h200000, 6'b010000, 0);
    send(32'h7FC0_0000, 32'h8000_0000, 3'b100);
    expect_result(0, 32'h7FC0_0000, 32'h8000_0000, 3'b100,
                  10'h080, 24'h400000, 6'b100000, 10'h382, 24'h000000, 6'b000001, 0);

    // Subnormal (lz=22, -148) with a normal 1.0, under 10 cycles of backpressure
    send(32'h0000_0003, 32'h3F80_0000, 3'b011);
    expect_result(22, 32'h0000_0003, 32'h3F80_0000, 3'b011,
                  10'h36C, 24'hC00000, 6'b000010, 10'h000, 24'h800000, 6'b000100, 10);

    // Accept right after the backpressured handshake
    send(32'h4000_0000, 32'h3FC0_0000, 3'b101);
    expect_result(0, 32'h4000_0000, 32'h3FC0_0000, 3'b101,
                  10'h001, 24'h800000, 6'b000100, 10'h000, 24'hC00000, 6'b000100, 0);

    // Reset during the 5th NORM cycle of the longest subnormal
    send(32'h0000_0001, 32'h3F80_0000, 3'b110);
    repeat (4) @(posedge clk);
    #1;
    check("mid_norm_state", 64'(bus.state_o), 64'd1);
    check("mid_norm_valid", 64'(bus.valid_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.valid_o), 64'd0);
    check("abort_ready", 64'(bus.ready_o), 64'd1);
    check("abort_data", {bus.rs1Sig_o, bus.rs1Exp_o, bus.rs1Class_o, bus.rm_o}, 64'd0);
    check("abort_state", 64'(bus.state_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(bus.valid_o), 64'd0);

    send(32'h3FC0_0000, 32'h4000_0000, 3'b001);
    expect_result(0, 32'h3FC0_0000, 32'h4000_0000, 3'b001,
                  10'h000, 24'hC00000, 6'b000100, 10'h001, 24'h800000, 6'b000100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
